// File: rtl/k054000_scan.sv
// k054000_scan: sequences 18 register writes and one status read into the 054000.
// Optional K054000_SCAN_SKIP_EN: shadow RAM skips bytes already in the checker.
module k054000_scan #(
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1,
   parameter int READ_CYC  = 2,
   parameter int TAG_W     = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [143:0]     in_data,
   input  logic [TAG_W-1:0] in_tag,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_hit,
   output logic [TAG_W-1:0] res_tag,
   output logic [4:0]       K_A,
   output logic [7:0]       K_DO,
   input  logic [7:0]       K_DI,
   output logic             K_CS,
   output logic             K_NWR
);

   localparam int M1   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int M2   = (HOLD_CYC > READ_CYC) ? HOLD_CYC : READ_CYC;
   localparam int MAXC = (M1 > M2) ? M1 : M2;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [4:0] RD_ADDR = 5'h18;

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_STROBE, S_HOLD,
      S_GAP, S_RSETUP, S_RSAMPLE, S_RESULT
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [4:0]       k_q, k_d;
   logic [4:0]       a_q, a_d;
   logic [7:0]       do_q, do_d;
   logic             hit_q, hit_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [143:0]     data_q, data_d;
   logic             hold_done, rd_done;
   logic [5:0]       nx_in, nx_q;
   logic [17:0][7:0] in_b, dat_b;
   logic             unused_di;

   assign in_b      = in_data;
   assign dat_b     = data_q;
   assign unused_di = ^K_DI[7:1];

   function automatic logic [4:0] addr_of(input logic [4:0] k);
      case (k)
         5'd0:    return 5'h01;
         5'd1:    return 5'h02;
         5'd2:    return 5'h03;
         5'd3:    return 5'h04;
         5'd4:    return 5'h06;
         5'd5:    return 5'h07;
         5'd6:    return 5'h09;
         5'd7:    return 5'h0A;
         5'd8:    return 5'h0B;
         5'd9:    return 5'h0C;
         5'd10:   return 5'h0E;
         5'd11:   return 5'h0F;
         5'd12:   return 5'h11;
         5'd13:   return 5'h12;
         5'd14:   return 5'h13;
         5'd15:   return 5'h15;
         5'd16:   return 5'h16;
         5'd17:   return 5'h17;
         default: return 5'h00;
      endcase
   endfunction

`ifdef K054000_SCAN_SKIP_EN
   logic [7:0]  shd_q [18];
   logic        shv_q;
   logic [17:0] dif_in, dif_q;

   // {found, index} of the lowest set bit at or above 'from'
   function automatic logic [5:0] first_set(input logic [17:0] v,
                                            input logic [4:0] from);
      logic [5:0] r;
      r = '0;
      for (int i = 17; i >= 0; i--)
         if (v[i] && (5'(i) >= from)) r = {1'b1, 5'(i)};
      return r;
   endfunction

   always_comb begin
      dif_in = '0;
      dif_q  = '0;
      for (int i = 0; i < 18; i++) begin
         dif_in[i] = !shv_q || (in_b[i] != shd_q[i]);
         dif_q[i]  = !shv_q || (dat_b[i] != shd_q[i]);
      end
   end

   assign nx_in = first_set(dif_in, 5'd0);
   assign nx_q  = first_set(dif_q, k_q + 5'd1);

   always_ff @(posedge CLK) begin
      if (RESET) shv_q <= 1'b0;
      else if (rd_done) shv_q <= 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (hold_done) shd_q[k_q] <= dat_b[k_q];
   end
`else
   assign nx_in = 6'b1_00000;
   assign nx_q  = (k_q == 5'd17) ? 6'd0 : {1'b1, k_q + 5'd1};
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      k_d       = k_q;
      a_d       = a_q;
      do_d      = do_q;
      hit_d     = hit_q;
      tag_d     = tag_q;
      data_d    = data_q;
      hold_done = 1'b0;
      rd_done   = 1'b0;
      unique case (state_q)
         S_IDLE: if (in_valid) begin
            data_d = in_data;
            tag_d  = in_tag;
            if (nx_in[5]) begin
               state_d = S_SETUP;
               k_d     = nx_in[4:0];
               a_d     = addr_of(nx_in[4:0]);
               do_d    = in_b[nx_in[4:0]];
               cnt_d   = CW'(SETUP_CYC - 1);
            end else begin
               state_d = S_RSETUP;
               a_d     = RD_ADDR;
               cnt_d   = CW'(READ_CYC - 1);
            end
         end
         S_SETUP: if (cnt_q == '0) begin
            state_d = S_STROBE;
            cnt_d   = CW'(PULSE_CYC - 1);
         end else cnt_d = cnt_q - 1'b1;
         S_STROBE: if (cnt_q == '0) begin
            state_d = S_HOLD;
            cnt_d   = CW'(HOLD_CYC - 1);
         end else cnt_d = cnt_q - 1'b1;
         S_HOLD: if (cnt_q == '0) begin
            state_d   = S_GAP;
            hold_done = 1'b1;
         end else cnt_d = cnt_q - 1'b1;
         S_GAP: if (nx_q[5]) begin
            state_d = S_SETUP;
            k_d     = nx_q[4:0];
            a_d     = addr_of(nx_q[4:0]);
            do_d    = dat_b[nx_q[4:0]];
            cnt_d   = CW'(SETUP_CYC - 1);
         end else begin
            state_d = S_RSETUP;
            a_d     = RD_ADDR;
            cnt_d   = CW'(READ_CYC - 1);
         end
         S_RSETUP: if (cnt_q == '0) begin
            state_d = S_RSAMPLE;
            hit_d   = ~K_DI[0];
            rd_done = 1'b1;
         end else cnt_d = cnt_q - 1'b1;
         S_RSAMPLE: state_d = S_RESULT;
         S_RESULT: if (res_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         k_q     <= '0;
         a_q     <= '0;
         do_q    <= '0;
         hit_q   <= 1'b0;
         tag_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         a_q     <= a_d;
         do_q    <= do_d;
         hit_q   <= hit_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign res_valid = (state_q == S_RESULT);
   assign res_hit   = hit_q;
   assign res_tag   = tag_q;
   assign K_A       = a_q;
   assign K_DO      = do_q;
   assign K_NWR     = (state_q != S_STROBE);
   assign K_CS      = (state_q == S_SETUP) || (state_q == S_STROBE) ||
                      (state_q == S_HOLD)  || (state_q == S_RSETUP);

endmodule

// File: tb/tb_k054000_scan.sv
// tb_k054000_scan: random and directed descriptors against a cycle-offset
// model of the bus trace; build with +define+K054000_SCAN_SKIP_EN for skip mode.
module tb_k054000_scan;

   localparam int S  = 1;
   localparam int PU = 2;
   localparam int H  = 1;
   localparam int RD = 2;
   localparam int P  = S + PU + H + 1;
`ifdef K054000_SCAN_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic         clk, RESET;
   logic         in_valid, in_ready, res_valid, res_ready, res_hit;
   logic [143:0] in_data;
   logic [3:0]   in_tag, res_tag;
   logic [4:0]   K_A;
   logic [7:0]   K_DO, k_di;
   logic         K_CS, K_NWR;

   k054000_scan dut (
      .CLK(clk), .RESET(RESET),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_tag(in_tag),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_hit(res_hit), .res_tag(res_tag),
      .K_A(K_A), .K_DO(K_DO), .K_DI(k_di),
      .K_CS(K_CS), .K_NWR(K_NWR)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cmp_n = 0;
   int err_n = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [4:0] tbl [18] = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h06, 5'h07,
                            5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0E, 5'h0F,
                            5'h11, 5'h12, 5'h13, 5'h15, 5'h16, 5'h17};

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      cmp_n++;
      if (act !== exp) begin
         err_n++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] byte_of(input logic [143:0] d, input int k);
      return d[8*k +: 8];
   endfunction

   function automatic logic [143:0] rnd144();
      logic [143:0] r;
      for (int k = 0; k < 18; k++) r[8*k +: 8] = 8'($urandom_range(0, 255));
      return r;
   endfunction

   // model: mode 0 idle, 1 busy (off = cycles since accept), 2 result
   int           mode = 0;
   int           off  = 0;
   logic [143:0] mdat;
   logic [3:0]   mtag;
   logic         mhit, mshv;
   logic [7:0]   msh [18];
   int           mwl [$];
   bit           live = 0;

   always @(posedge clk) begin
      int w;
      if (RESET) begin
         mode = 0; mshv = 1'b0; mhit = 1'b0; mtag = 4'd0; live = 1;
      end else begin
         case (mode)
            0: if (in_valid) begin
               mdat = in_data;
               mtag = in_tag;
               mwl.delete();
               for (int k = 0; k < 18; k++)
                  if (!SKIP || !mshv || byte_of(mdat, k) != msh[k])
                     mwl.push_back(k);
               mode = 1;
               off  = 1;
            end
            1: begin
               w = mwl.size();
               if (off <= P*w && (off-1) % P == S+PU+H-1)
                  msh[mwl[(off-1)/P]] = byte_of(mdat, mwl[(off-1)/P]);
               if (off == P*w + RD) begin
                  mhit = ~k_di[0];
                  mshv = 1'b1;
               end
               off++;
               if (off == P*w + RD + 2) mode = 2;
            end
            default: if (res_ready) mode = 0;
         endcase
      end
   end

   logic [4:0] wa [$];
   int         run = 0;
   logic       pcs = 1'b0;
   logic [4:0] pa;
   logic [7:0] pd;

   always @(negedge clk) if (live) begin
      logic       ecs, enwr, ea_v, ed_v;
      logic [4:0] ea;
      logic [7:0] ed;
      int         w, j, p;
      ecs = 0; enwr = 1; ea_v = 0; ed_v = 0; ea = '0; ed = '0;
      w = mwl.size();
      if (mode == 1) begin
         if (off <= P*w) begin
            j    = (off-1) / P;
            p    = (off-1) % P;
            ecs  = (p < S+PU+H);
            enwr = !(p >= S && p < S+PU);
            ea   = tbl[mwl[j]];
            ed   = byte_of(mdat, mwl[j]);
            ea_v = ecs;
            ed_v = ecs;
         end else if (off <= P*w + RD) begin
            ecs  = 1;
            ea   = 5'h18;
            ea_v = 1;
         end
      end
      chk("in_ready", in_ready, mode == 0);
      chk("res_valid", res_valid, mode == 2);
      chk("res_hit", res_hit, mhit);
      chk("res_tag", res_tag, mtag);
      chk("K_CS", K_CS, ecs);
      chk("K_NWR", K_NWR, enwr);
      if (ea_v) chk("K_A", K_A, ea);
      if (ed_v) chk("K_DO", K_DO, ed);
      if (RESET) run = 0;
      else if (!K_NWR) begin
         if (run == 0) wa.push_back(K_A);
         run++;
      end else if (run > 0) begin
         chk("nwr_width", run, PU);
         run = 0;
      end
      if (K_CS && pcs) begin
         chk("a_stable", K_A, pa);
         chk("d_stable", K_DO, pd);
      end
      pcs = K_CS; pa = K_A; pd = K_DO;
   end

   task automatic send(input logic [143:0] d, input logic [3:0] t,
                       input logic d0, input int stall,
                       output int lat, output int nw,
                       output logic rh, output logic [3:0] rt);
      int n;
      int acc;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 400) begin @(negedge clk); n++; end
      chk("rdy_wait", in_ready, 1'b1);
      in_data  = d;
      in_tag   = t;
      in_valid = 1'b1;
      k_di     = 8'($urandom);
      k_di[0]  = d0;
      wa.delete();
      @(posedge clk); #1;
      acc      = cyc;
      in_valid = 1'b0;
      in_data  = rnd144();
      in_tag   = 4'($urandom);
      n = 0;
      @(negedge clk);
      while (!res_valid && n < 400) begin @(negedge clk); n++; end
      chk("rv_wait", res_valid, 1'b1);
      lat = cyc - acc;
      rh  = res_hit;
      rt  = res_tag;
      if (stall > 0) begin
         in_valid = 1'b1;
         in_data  = rnd144();
         repeat (stall) begin
            chk("stall_rdy", in_ready, 1'b0);
            chk("stall_rv", res_valid, 1'b1);
            chk("stall_cs", K_CS, 1'b0);
            @(negedge clk);
         end
         in_valid = 1'b0;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      nw = wa.size();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [143:0] d, d3, df;
      logic         rh;
      logic [3:0]   rt;
      int           lat, nw, n;
      RESET = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
      in_data = '0; in_tag = '0; k_di = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_res_hit", res_hit, 1'b0);
      chk("rst_res_tag", res_tag, 4'd0);
      chk("rst_cs", K_CS, 1'b0);
      chk("rst_nwr", K_NWR, 1'b1);
      chk("rst_a", K_A, 5'd0);
      chk("rst_do", K_DO, 8'd0);
      @(posedge clk); #1 RESET = 1'b0;

      send('0, 4'd3, 1'b0, 0, lat, nw, rh, rt);
      chk("t1_lat", lat, 93);
      chk("t1_hit", rh, 1'b1);
      chk("t1_tag", rt, 4'd3);
      chk("t1_nw", nw, 18);
      for (int i = 0; i < wa.size() && i < 18; i++) chk("t1_order", wa[i], tbl[i]);

      d = '0; d[7:0] = 8'hFF;
      send(d, 4'd5, 1'b1, 0, lat, nw, rh, rt);
      chk("t2_hit", rh, 1'b0);
      chk("t2_tag", rt, 4'd5);
      chk("t2_nw", nw, SKIP ? 1 : 18);
      chk("t2_lat", lat, SKIP ? 8 : 93);

      d3 = rnd144();
      send(d3, 4'd9, 1'b0, 10, lat, nw, rh, rt);
      chk("t3_tag", rt, 4'd9);

      @(negedge clk);
      in_data = d3 ^ {18{8'hA5}}; in_tag = 4'd7; in_valid = 1'b1;
      wa.delete();
      @(posedge clk); #1 in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!(K_CS && !K_NWR && K_A == 5'h09) && n < 200) begin
         @(negedge clk); n++;
      end
      chk("t4_strobe9", K_A, 5'h09);
      @(posedge clk); #1;
      chk("t4_nth", wa.size(), 7);
      RESET = 1'b1;
      @(posedge clk); #1 RESET = 1'b0;
      @(negedge clk);
      chk("t4_cs", K_CS, 1'b0);
      chk("t4_nwr", K_NWR, 1'b1);
      chk("t4_rv", res_valid, 1'b0);
      chk("t4_rdy", in_ready, 1'b1);
      df = rnd144();
      send(df, 4'd2, 1'b1, 0, lat, nw, rh, rt);
      chk("t4_nw", nw, 18);
      chk("t4_lat", lat, 93);
      chk("t4_hit", rh, 1'b0);

      send(df, 4'd4, 1'b0, 0, lat, nw, rh, rt);
      chk("t5_nw", nw, SKIP ? 0 : 18);
      chk("t5_lat", lat, SKIP ? 3 : 93);
      chk("t5_hit", rh, 1'b1);
      df[143:136] = df[143:136] ^ 8'h3C;
      send(df, 4'd6, 1'b1, 0, lat, nw, rh, rt);
      chk("t5b_nw", nw, SKIP ? 1 : 18);
      chk("t5b_lat", lat, SKIP ? 8 : 93);
      if (wa.size() > 0) chk("t5b_addr", wa[0], SKIP ? 5'h17 : 5'h01);

      for (int it = 0; it < 20; it++) begin
         if ($urandom_range(0, 1) == 0) df = rnd144();
         else
            repeat ($urandom_range(0, 3))
               df[8*$urandom_range(0, 17) +: 8] = 8'($urandom);
         send(df, 4'($urandom), 1'($urandom), $urandom_range(0, 3),
              lat, nw, rh, rt);
      end

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end

endmodule
